// File: rtl/posit_to_fp_pipe.sv
// Posit(N, es) to IEEE-754 binary FP converter, three pipeline stages.
// S1 classifies the operand and takes its magnitude, S2 decodes the regime,
// exponent and fraction, and S3 rounds to nearest-even and saturates or flushes.
// A single enable stalls every stage together when the output is held.
module posit_to_fp_pipe #(
    parameter int N  = 32,
    parameter int E  = 8,
    parameter int es = 4,
    parameter int Bs = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int M    = N - E - 1;           // FP mantissa width
    localparam int FW   = N - 1 - es;          // fraction width after regime/exponent removal
    localparam int SW   = Bs + es + 2;         // signed scale width
    localparam int BIAS = (1 << (E - 1)) - 1;
    localparam int EMAX = (1 << E) - 1;

    localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] QNAN   = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    localparam logic [N-2:0] MAXMAG = {{(E-1){1'b1}}, 1'b0, {M{1'b1}}};

    logic en;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // ---------------- S1: classify and absolute value ----------------
    logic         v1, s1, z1, n1;
    logic [N-2:0] mag1;

    // Capture sign, special flags and magnitude of the incoming posit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            s1   <= 1'b0;
            z1   <= 1'b0;
            n1   <= 1'b0;
            mag1 <= '0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1   <= in[N-1];
                z1   <= (in == '0);
                n1   <= (in == NAR);
                // Low N-1 bits of the two's complement depend only on the low N-1 input bits.
                mag1 <= in[N-1] ? -in[N-2:0] : in[N-2:0];
            end
        end
    end

    // ---------------- S2: regime decode ----------------
    logic [N-2:0]  probe;
    logic [N-2:0]  scan;
    logic [Bs-1:0] run;
    logic          run_end;
    logic [Bs:0]   k;
    logic [Bs:0]   shamt;
    logic [N-2:0]  tail;
    logic [SW-1:0] sc;

    // Measure the regime run, derive k, and strip regime plus terminator.
    always_comb begin
        probe   = ~(mag1 ^ {(N-1){mag1[N-2]}});
        scan    = probe;
        run     = '0;
        run_end = 1'b0;
        for (int unsigned i = 0; i < N - 1; i++) begin
            if (!run_end && scan[N-2]) run = run + Bs'(1);
            else                       run_end = 1'b1;
            scan = scan << 1;
        end
        k     = mag1[N-2] ? ({1'b0, run} - (Bs+1)'(1)) : ((Bs+1)'(0) - {1'b0, run});
        shamt = {1'b0, run} + (Bs+1)'(1);
        tail  = mag1 << shamt;
        // k * 2^es + e is just k concatenated with the es exponent bits.
        sc    = {{(SW-Bs-1-es){k[Bs]}}, k, tail[N-2 -: es]};
    end

    logic          v2, s2, z2, n2;
    logic [SW-1:0] sc2;
    logic [FW-1:0] frac2;

    // Register decoded scale and MSB-aligned fraction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            s2    <= 1'b0;
            z2    <= 1'b0;
            n2    <= 1'b0;
            sc2   <= '0;
            frac2 <= '0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                s2    <= s1;
                z2    <= z1;
                n2    <= n1;
                sc2   <= sc;
                frac2 <= tail[FW-1:0];
            end
        end
    end

    // ---------------- S3: round, saturate, assemble ----------------
    logic [M-1:0]       mant;
    logic               guard, sticky, rnd;
    logic [M:0]         mant_r;
    logic signed [SW:0] xb;
    logic [N-1:0]       result;

    // Round to nearest-even, rebias, then apply special/saturate/flush priority.
    always_comb begin
        mant   = frac2[FW-1 -: M];
        guard  = frac2[FW-1-M];
        sticky = |frac2[FW-2-M:0];
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {{M{1'b0}}, rnd};
        xb     = $signed({sc2[SW-1], sc2}) + $signed((SW+1)'(BIAS))
               + $signed({{SW{1'b0}}, mant_r[M]});
        if (n2)                                  result = QNAN;
        else if (z2)                             result = '0;
        else if (xb >= $signed((SW+1)'(EMAX)))   result = {s2, MAXMAG};
        else if (xb <= $signed((SW+1)'(0)))      result = {s2, {(N-1){1'b0}}};
        else                                     result = {s2, xb[E-1:0], mant_r[M-1:0]};
    end

    // Output register; holds value and valid while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else if (en) begin
            out_valid <= v2;
            if (v2) out <= result;
        end
    end

endmodule

// File: tb/tb_posit_to_fp_pipe.sv
// Self-checking bench for posit_to_fp_pipe (N=32, E=8, es=4).
module tb_posit_to_fp_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] p;
        logic [31:0] exp;
        logic [31:0] orig;
        int          tol;
        bit          rt;
    } item_t;

    item_t stim[$];

    posit_to_fp_pipe #(.N(32), .E(8), .es(4), .Bs(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference: decode posit to sign/scale/real fraction, then round into FP32.
    function automatic logic [31:0] ref_conv(input logic [31:0] p);
        logic [31:0] m;
        logic        b, s;
        int          i, r, k, e, sc, ip;
        real         f, w, scaled, rem;
        if (p == 32'h0000_0000) return 32'h0000_0000;
        if (p == 32'h8000_0000) return 32'h7FC0_0000;
        s = p[31];
        m = s ? (~p + 32'd1) : p;
        b = m[30];
        r = 0;
        i = 30;
        while (i >= 0 && m[i] == b) begin r++; i--; end
        k = b ? r - 1 : -r;
        i--;
        e = 0;
        for (int j = 0; j < 4; j++) begin
            e = e * 2 + ((i >= 0 && m[i] == 1'b1) ? 1 : 0);
            i--;
        end
        f = 1.0;
        w = 0.5;
        while (i >= 0) begin
            if (m[i] == 1'b1) f = f + w;
            w = w / 2.0;
            i--;
        end
        sc     = k * 16 + e;
        scaled = (f - 1.0) * 8388608.0;
        ip     = $rtoi(scaled);
        rem    = scaled - ip;
        if (rem > 0.5 || (rem == 0.5 && (ip % 2) == 1)) ip++;
        if (ip == 8388608) begin ip = 0; sc++; end
        if (sc + 127 >= 255) return {s, 31'h7F7F_FFFF};
        if (sc + 127 <= 0)   return {s, 31'h0};
        return {s, 8'(sc + 127), 23'(ip)};
    endfunction

    // Truncating FP32 -> posit encoder for positive normals; tol is one posit ulp in FP ulps.
    function automatic logic [31:0] fp_to_posit(input logic [31:0] w, output int tol);
        int          sc, k, e, reg_len, n, fb;
        logic [63:0] acc;
        sc  = int'(w[30:23]) - 127;
        k   = sc >>> 4;
        e   = sc & 15;
        acc = '0;
        n   = 0;
        if (k >= 0) begin
            for (int j = 0; j <= k; j++) begin acc = {acc[62:0], 1'b1}; n++; end
            acc = {acc[62:0], 1'b0}; n++;
            reg_len = k + 1;
        end else begin
            for (int j = 0; j < -k; j++) begin acc = {acc[62:0], 1'b0}; n++; end
            acc = {acc[62:0], 1'b1}; n++;
            reg_len = -k;
        end
        for (int j = 3; j >= 0; j--)  begin acc = {acc[62:0], e[j]}; n++; end
        for (int j = 22; j >= 0; j--) begin acc = {acc[62:0], w[j]}; n++; end
        if (n >= 31) acc = acc >> (n - 31);
        else         acc = acc << (31 - n);
        fb  = 26 - reg_len;
        tol = (fb >= 23) ? 1 : (1 << (23 - fb));
        return {1'b0, acc[30:0]};
    endfunction

    function automatic void add(input logic [31:0] p, input logic [31:0] e);
        item_t it;
        it.p = p; it.exp = e; it.orig = '0; it.tol = 0; it.rt = 1'b0;
        stim.push_back(it);
    endfunction

    // Streams stim through the DUT with optional gaps and an out_ready stall window.
    task automatic run_stream(input int stall_start, input int stall_len, input bit gaps, input bit chk_lat);
        item_t       fly[$];
        int          acc_cyc[$];
        item_t       it;
        int          cyc, idx, budget, a;
        logic        prev_hold;
        logic [31:0] prev_out, diff;
        cyc = 0; idx = 0; prev_hold = 1'b0; prev_out = '0;
        budget = stim.size() * 5 + 40;
        while ((idx < stim.size() || fly.size() != 0) && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            in_valid  = (idx < stim.size()) && (!gaps || $urandom_range(0, 3) != 0);
            in        = in_valid ? stim[idx].p : $urandom;
            @(negedge clk);
            n_checks++;
            if (in_ready !== (out_ready || !out_valid))
                $display("FAIL in_ready: got %b expected %b (out_valid=%b out_ready=%b)",
                         in_ready, (out_ready || !out_valid), out_valid, out_ready);
            else n_pass++;
            if (prev_hold) begin
                n_checks++;
                if (out_valid !== 1'b1 || out !== prev_out)
                    $display("FAIL stall_hold: got valid=%b out=%h expected valid=1 out=%h", out_valid, out, prev_out);
                else n_pass++;
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = out;
            if (in_valid && in_ready) begin
                fly.push_back(stim[idx]);
                acc_cyc.push_back(cyc);
                idx++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (fly.size() == 0) begin
                    $display("FAIL spurious_output: got %h expected no output", out);
                end else begin
                    it = fly.pop_front();
                    a  = acc_cyc.pop_front();
                    if (out !== it.exp)
                        $display("FAIL result(in=%h): got %h expected %h", it.p, out, it.exp);
                    else n_pass++;
                    if (chk_lat) begin
                        n_checks++;
                        if (cyc - a != 3) $display("FAIL latency(in=%h): got %0d expected 3", it.p, cyc - a);
                        else n_pass++;
                    end
                    if (it.rt) begin
                        n_checks++;
                        diff = (out > it.orig) ? out - it.orig : it.orig - out;
                        if ($isunknown(out) || diff > it.tol)
                            $display("FAIL roundtrip(fp=%h): got %h expected within %0d ulp", it.orig, out, it.tol);
                        else n_pass++;
                    end
                end
            end
        end
        n_checks++;
        if (idx < stim.size() || fly.size() != 0)
            $display("FAIL stream_timeout: got %0d sent/%0d pending expected all %0d drained", idx, fly.size(), stim.size());
        else n_pass++;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stim.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in = '0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || out !== 32'h0)
            $display("FAIL reset_state: got valid=%b out=%h expected valid=0 out=00000000", out_valid, out);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 32'h0)
                $display("FAIL post_reset_idle: got valid=%b ready=%b out=%h expected 0/1/00000000", out_valid, in_ready, out);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        add(32'h4000_0000, 32'h3F80_0000);
        add(32'h4200_0000, 32'h4000_0000);
        add(32'hC000_0000, 32'hBF80_0000);
        run_stream(0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_specials_rounding();
        add(32'h0000_0000, 32'h0000_0000);
        add(32'h8000_0000, 32'h7FC0_0000);
        add(32'h7FFF_FFFF, 32'h7F7F_FFFF);
        add(32'h8000_0001, 32'hFF7F_FFFF);
        add(32'h0000_0001, 32'h0000_0000);
        add(32'h4000_0003, 32'h3F80_0001);
        add(32'h4000_0002, 32'h3F80_0000);
        add(32'h4000_0006, 32'h3F80_0002);
        run_stream(0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        for (int j = 0; j < 8; j++) begin
            r = $urandom;
            r = (r & 32'hFFFF_FF00) | 32'(j);
            add(r, ref_conv(r));
        end
        run_stream(5, 5, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] r, r2, p;
        for (int j = 0; j < 300; j++) begin
            r  = $urandom;
            r2 = $urandom;
            case ($urandom_range(0, 3))
                0:       p = r;
                1:       p = {r2[0], 2'b10, r[28:0]};
                2:       begin p = r >> r2[4:0]; if (r2[5]) p = -p; end
                default: begin p = {1'b0, 2'b10, r[28:2], 2'b10}; if (r2[0]) p = -p; end
            endcase
            add(p, ref_conv(p));
        end
        run_stream(20, 4, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midstream();
        logic [31:0] ops [3];
        ops = '{32'h4000_0000, 32'h4200_0000, 32'hC000_0000};
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in = ops[j];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out !== 32'h3F80_0000)
            $display("FAIL pre_reset_out: got valid=%b out=%h expected valid=1 out=3f800000", out_valid, out);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out !== 32'h0)
            $display("FAIL async_reset: got valid=%b out=%h expected valid=0 out=00000000", out_valid, out);
        else n_pass++;
        @(posedge clk); #2;
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0)
                $display("FAIL stale_after_reset: got valid=%b expected 0", out_valid);
            else n_pass++;
        end
        @(posedge clk); #1;
        in = 32'h4200_0000;
        in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL accept_after_reset: got ready=%b expected 1", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            n_checks++;
            if (j < 3) begin
                if (out_valid !== 1'b0) $display("FAIL early_result(+%0d): got valid=%b expected 0", j, out_valid);
                else n_pass++;
            end else begin
                if (out_valid !== 1'b1 || out !== 32'h4000_0000)
                    $display("FAIL first_after_reset: got valid=%b out=%h expected valid=1 out=40000000", out_valid, out);
                else n_pass++;
            end
        end
    endtask

    task automatic test_roundtrip();
        item_t       it;
        int          tol;
        logic [31:0] w;
        w = 32'h0080_FFFF;
        while (w <= 32'h7F7F_FFFF) begin
            it.p    = fp_to_posit(w, tol);
            it.exp  = ref_conv(it.p);
            it.orig = w;
            it.tol  = tol;
            it.rt   = 1'b1;
            stim.push_back(it);
            w = w + 32'd65535;
        end
        run_stream(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_specials_rounding();
        test_backpressure();
        test_random();
        test_reset_midstream();
        test_roundtrip();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/posit_to_fp_pipe.md
Name: posit_to_FP_pipe

Overview:
- Pipelined converter from N-bit posit (es exponent bits) to IEEE-754 binary floating point (E exponent bits, N-E-1 fraction bits).
- Inverse of the FP-to-posit converter. Sits on the posit datapath egress and feeds FP consumers.
- Uses a valid/ready stream on both sides, 3-stage pipeline, one result per cycle when not stalled.

Parameters:
N, 32, posit and FP word width
E, 8, FP exponent width (bias = 2^(E-1)-1 = 127)
es, 4, posit exponent field width
Bs, log2(N), width of regime run counter (5 for N=32)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in  in  N  posit operand
in_valid  in  1  operand valid
in_ready  out  1  converter can accept operand this cycle
out  out  N  FP result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result

Behaviour:
- Reset (async, active-high): all stage valids and out_valid = 0; out = 0; all data regs = 0. Reset mid-operation discards in-flight operands. Nothing emerges after rst deasserts.
- Global enable: en = out_ready | ~out_valid. in_ready = en (combinational). All three stages advance together when en=1 and hold when en=0.
- Transfer rules: input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
- Stalling: under stall, out and out_valid stay stable. Bubbles fill on the next enabled cycle.
- Latency: an operand accepted on cycle t appears on out at cycle t+3 if no stall. Throughput is 1 per cycle.
- S1 (classify/abs):
  - Register the sign s = in[N-1].
  - Register flags isZero (in==0) and isNaR (in==1<<(N-1)).
  - Register the magnitude: two's complement of in if s=1, else in.
- S2 (regime decode):
  - Run length r = count of leading bits equal to mag[N-2], starting at bit N-2. Range 1..N-1.
  - k = r-1 if the run is ones, k = -r if the run is zeros.
  - Left-shift out the sign, regime and terminator. The next es bits form e (zero-filled if truncated); the remainder is the fraction, MSB-aligned.
  - Scale sc = k*2^es + e, signed, width Bs+es+2.
- S3 (assemble/round/saturate):
  - Biased exponent x = sc + bias.
  - Keep the top N-E-1 fraction bits. Guard = next bit; sticky = OR of the rest.
  - Round to nearest, ties to even. A mantissa carry-out increments x.
- S3 outcome priority, first match wins:
  1. isNaR -> 0x7FC00000 (quiet NaN, sign 0).
  2. isZero -> 0x00000000.
  3. x (after rounding) >= 2^E-1 -> saturate to {s, 0x7F7FFFFF[N-2:0]}, i.e. ±max normal. Never ±inf.
  4. x <= 0 -> flush to signed zero {s, 0...}. No subnormals are produced.
  5. Otherwise -> {s, x[E-1:0], mantissa}.
- Simultaneous events: a new operand and output acceptance in the same cycle is normal streaming. rst overrides everything.

Test Plan:
- Basic values, in_valid=1, out_ready=1: 0x40000000 -> 0x3F800000 (1.0); 0x42000000 -> 0x40000000 (2.0); 0xC0000000 -> 0xBF800000 (-1.0). Each appears exactly 3 cycles after acceptance.
- Specials: 0x00000000 -> 0x00000000; 0x80000000 -> 0x7FC00000; 0x7FFFFFFF -> 0x7F7FFFFF (saturate); 0x80000001 -> 0xFF7FFFFF; 0x00000001 -> 0x00000000 (flush).
- Rounding: 0x40000003 -> 0x3F800001 (round up); 0x40000002 -> 0x3F800000 (tie to even); 0x40000006 -> 0x3F800002 (tie, odd kept LSB rounds up).
- Backpressure: stream 8 distinct operands and hold out_ready=0 for 5 cycles mid-stream. Required: in_ready=0 while out_valid=1; out stable throughout; no loss or duplication; results arrive in order.
- Reset mid-stream: assert rst asynchronously with 3 operands in flight. Required: out_valid=0 and out=0 immediately; no stale result after release; the first new operand returns at +3 cycles.
- Round-trip sweep: drive FP words from 0x0080FFFF to 0x7F7FFFFF in steps of 65535 through the FP-to-posit converter and then this block. Required: every result is within 1 ulp of the original where the posit precision allows, with no X on out.
